// File: rtl/q78_pkg.sv
// Shared types and constants for the Q7.8 conversion arbiter slice.
// Imported by q78_id_fifo and q78_conv_arbiter.
package q78_pkg;

  localparam int FP32_W = 32;
  localparam int Q78_W  = 16;
  localparam int CNT_W  = 16;

  localparam logic signed [Q78_W-1:0] Q78_MAX = 16'sh7FFF;
  localparam logic signed [Q78_W-1:0] Q78_MIN = 16'sh8000;

  typedef logic signed [Q78_W-1:0] q78_t;
  typedef logic        [FP32_W-1:0] fp32_t;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/q78_id_fifo.sv
// In-order requester-id FIFO tracking beats in flight through the shared converter.
// A push while full is dropped here; the arbiter never issues one.
module q78_id_fifo
  import q78_pkg::*;
#(
  parameter int ID_W  = 2,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [ID_W-1:0] push_id,
  input  logic            pop,
  output logic [ID_W-1:0] head_id,
  output logic            full,
  output logic            empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ID_W-1:0] mem [DEPTH];
  logic [PTR_W:0]  wr_ptr;
  logic [PTR_W:0]  rd_ptr;
  logic            do_push;
  logic            do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head_id = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[PTR_W-1:0]] <= push_id;
        wr_ptr                 <= wr_ptr + (PTR_W+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/q78_conv_arbiter.sv
// Packet-granular round-robin share of one FP32->Q7.8 converter among N_REQ sources,
// with in-order return routing. Define Q78_ARB_STATS_EN to add per-requester pkt_cnt.
module q78_conv_arbiter
  import q78_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int ID_W       = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        s_axis_tvalid,
  output logic [N_REQ-1:0]        s_axis_tready,
  input  logic [FP32_W*N_REQ-1:0] s_axis_tdata,
  input  logic [N_REQ-1:0]        s_axis_tlast,
  output logic                    c_axis_tvalid,
  input  logic                    c_axis_tready,
  output logic [FP32_W-1:0]       c_axis_tdata,
  output logic                    c_axis_tlast,
  input  logic                    r_axis_tvalid,
  output logic                    r_axis_tready,
  input  logic [Q78_W-1:0]        r_axis_tdata,
  input  logic                    r_axis_tlast,
  output logic [N_REQ-1:0]        m_axis_tvalid,
  input  logic [N_REQ-1:0]        m_axis_tready,
  output logic [Q78_W*N_REQ-1:0]  m_axis_tdata,
  output logic [N_REQ-1:0]        m_axis_tlast
`ifdef Q78_ARB_STATS_EN
  ,
  output logic [CNT_W*N_REQ-1:0]  pkt_cnt
`endif
);

  arb_state_e      state;
  arb_state_e      state_nxt;
  logic [ID_W-1:0] gnt;
  logic [ID_W-1:0] gnt_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] rr_ptr_nxt;
  logic [ID_W-1:0] pick;
  logic            found;
  logic            c_fire;
  logic            r_fire;
  logic            fifo_full;
  logic            fifo_empty;
  logic [ID_W-1:0] head;

  assign c_fire = c_axis_tvalid & c_axis_tready;
  assign r_fire = r_axis_tvalid & r_axis_tready;

  q78_id_fifo #(
    .ID_W  (ID_W),
    .DEPTH (FIFO_DEPTH)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (c_fire),
    .push_id (gnt),
    .pop     (r_fire),
    .head_id (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Round-robin scan starting at rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!found && s_axis_tvalid[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ARB_IDLE;
      gnt    <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    rr_ptr_nxt = rr_ptr;
    case (state)
      ARB_IDLE: begin
        if (found) begin
          state_nxt = ARB_BUSY;
          gnt_nxt   = pick;
        end
      end
      ARB_BUSY: begin
        if (c_fire && c_axis_tlast) begin
          state_nxt  = ARB_IDLE;
          rr_ptr_nxt = (gnt == ID_W'(N_REQ-1)) ? '0 : gnt + ID_W'(1);
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Forward mux: the granted source drives the converter; holding off on a full
  // FIFO keeps the ready path free of any dependency on the return side.
  always_comb begin
    c_axis_tvalid = 1'b0;
    c_axis_tdata  = '0;
    c_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state == ARB_BUSY) begin
      c_axis_tvalid      = s_axis_tvalid[gnt] & ~fifo_full;
      c_axis_tdata       = s_axis_tdata[FP32_W*gnt +: FP32_W];
      c_axis_tlast       = s_axis_tlast[gnt];
      s_axis_tready[gnt] = c_axis_tready & ~fifo_full;
    end
  end

  // Return path: a beat with no recorded owner stalls rather than being dropped.
  always_comb begin
    m_axis_tvalid       = '0;
    m_axis_tvalid[head] = r_axis_tvalid & ~fifo_empty;
    r_axis_tready       = m_axis_tready[head] & ~fifo_empty;
  end

  assign m_axis_tdata = {N_REQ{r_axis_tdata}};
  assign m_axis_tlast = {N_REQ{r_axis_tlast}};

`ifdef Q78_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else if (r_fire && r_axis_tlast) begin
      pkt_cnt[CNT_W*head +: CNT_W] <= pkt_cnt[CNT_W*head +: CNT_W] + CNT_W'(1);
    end
  end
`endif

endmodule
